seg7_mmio: RTL
==============

# seg7_mmio

Memory-mapped four-digit seven-segment display controller. It acts as a bus responder on the core's `memread`/`memwrite` data-memory interface and sits alongside the RAM inside `MEMORY`, which routes `memrdata_o` through its read mux when `hit_o` is high. It holds a 16-bit hex value and control bits, and time-multiplexes the four common-anode digits onto `seg7_seg_o`/`seg7_an_o`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_F000. Register block base address; 16-byte aligned.
- `SCAN_DIV`, default 50000. Clock cycles per digit slot; ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `memread_i`  in  1  bus read strobe.
- `memwrite_i`  in  1  bus write strobe.
- `memaddr_i`  in  `ADDR_WIDTH`  byte address.
- `memwdata_i`  in  `WIDTH` (32)  write data.
- `memrdata_o`  out  `WIDTH`  registered read data.
- `hit_o`  out  1  registered; high the cycle after a read that addressed this block.
- `seg7_seg_o`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `seg7_an_o`  out  4  digit anodes, active-low; bit i = digit i, digit 0 rightmost.

## Operation
- Address decode: a bus access is selected when `memaddr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]`. The offset is `memaddr_i[3:2]`. Bits [1:0] are ignored.
- Registers:
  - 0x0 DATA (R/W). Bits [15:0] hold four hex nibbles; nibble i drives digit i. Bits [31:16] read 0, and writes to them are discarded.
  - 0x4 CTRL (R/W). Bit0 is EN. Bits [7:4] are BLANK[3:0]; a set bit blanks that digit. Other bits read 0.
  - 0x8 STATUS (RO). Bits [1:0] are the current digit index. Bits [31:16] are the frame counter. Other bits read 0. Writes are ignored.
  - 0xC is reserved. Reads return 0; writes are ignored.
- Writes take effect at the clock edge where a selected `memwrite_i` is sampled high. The whole word is written; there are no byte enables.
- Reads:
  - On a selected `memread_i`, `memrdata_o` and `hit_o` are loaded at the edge and held for exactly one cycle.
  - `memrdata_o` is 0 in any cycle following a non-selected or absent read.
  - A simultaneous read and write to the same register returns the pre-write value.
- Scan prescaler:
  - `pcnt` counts 0 to SCAN_DIV−1 and wraps.
  - On wrap, `idx` advances 0→1→2→3→0.
  - On the 3→0 transition, the 16-bit frame counter increments, wrapping FFFF→0000.
  - The prescaler and `idx` run regardless of EN.
- Output generation (registered, every cycle):
  - If EN=1 and BLANK[idx]=0: `seg7_an_o` = ~(4'b0001 << idx) and `seg7_seg_o` = hexdecode(DATA[4·idx+3 : 4·idx]).
  - Otherwise: `seg7_an_o` = 4'hF and `seg7_seg_o` = 7'h7F.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values, held while `rst`=1:
  - DATA=0, CTRL=32'h1, `pcnt`=0, `idx`=0, frame counter=0.
  - `memrdata_o`=0, `hit_o`=0, `seg7_an_o`=4'hF, `seg7_seg_o`=7'h7F.
- First cycle after reset deasserts: the output registers load from `idx`=0, giving `seg7_an_o`=4'hE and `seg7_seg_o`=1000000 one edge later.
- Read latency is 1 cycle: request at edge N, data valid in the cycle after edge N.
- Bus is back-to-back capable. There is no stall and no ready signal.
- Write-to-display latency is 1 cycle: a DATA or CTRL write at edge N is reflected on the outputs after edge N+1 if it affects the current digit.
- Each digit is active for exactly SCAN_DIV cycles. A frame is 4·SCAN_DIV cycles.
- `rst` asserted mid-scan or mid-access: all state returns to reset values at that edge, and any pending read response is dropped (`hit_o`=0).

## Test plan
- Reset and scan, SCAN_DIV=4: after reset with no bus traffic, `seg7_an_o` steps E→D→B→7→E, 4 cycles each, `seg7_seg_o`=1000000 throughout, and STATUS frame count reads 1 after 16 cycles.
- Display data: write DATA=32'hFFFF_1A3F, then read DATA. The read returns 32'h0000_1A3F, and the segments show F, 3, A, 1 on digits 0 to 3 (0001110, 0110000, 0001000, 1111001).
- Blank and enable:
  - Write CTRL=32'h51. Digits 0 and 2 show an=F and seg=7F during their slots; digits 1 and 3 light normally.
  - Write CTRL=0. All outputs go off within 1 cycle.
- Read-during-write: with DATA=32'h1234, issue read and write of 32'h5678 to DATA in the same cycle. `memrdata_o`=32'h1234 and `hit_o`=1 for one cycle. A following read returns 32'h5678.
- Decode misses:
  - Access BASE_ADDR+0x10 and 0x0: `hit_o` stays 0 and `memrdata_o`=0.
  - Access BASE_ADDR+0xC: `hit_o`=1, data 0, and the write has no effect.
- Mid-operation reset: assert `rst` for 1 cycle during a read at `idx`=2. Next cycle shows `hit_o`=0, `memrdata_o`=0, an=F, seg=7F; then DATA reads 0 and CTRL reads 1.

Source files
------------

// File: rtl/seg7_mmio.sv
// Memory-mapped four-digit seven-segment display controller.
// Bus responder with DATA/CTRL/STATUS registers and a digit scanner.
module seg7_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
  parameter int          SCAN_DIV   = 50000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic [ADDR_WIDTH-1:0] memaddr_i,
  input  logic [WIDTH-1:0]      memwdata_i,
  output logic [WIDTH-1:0]      memrdata_o,
  output logic                  hit_o,
  output logic [6:0]            seg7_seg_o,
  output logic [3:0]            seg7_an_o
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [15:0]      r_data;
  logic             r_en;
  logic [3:0]       r_blank;
  logic [PW-1:0]    r_pcnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_frame;
  logic [WIDTH-1:0] r_rdata;
  logic             r_hit;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_sel;
  logic [1:0]       w_off;
  logic             w_rd;
  logic             w_wr;
  logic             w_wrap;
  logic [3:0]       w_nib;
  logic [WIDTH-1:0] w_rdval;
  logic             w_unused;

  assign w_sel  = memaddr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  assign w_off  = memaddr_i[3:2];
  assign w_rd   = memread_i && w_sel;
  assign w_wr   = memwrite_i && w_sel;
  assign w_wrap = r_pcnt == PMAX;
  assign w_nib  = r_data[{r_idx, 2'b00} +: 4];
  assign w_unused = ^{memwdata_i[WIDTH-1:16], memaddr_i[1:0]};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Read mux sees pre-write register values.
  always_comb begin
    w_rdval = '0;
    unique case (w_off)
      2'd0: w_rdval[15:0] = r_data;
      2'd1: begin
        w_rdval[0]   = r_en;
        w_rdval[7:4] = r_blank;
      end
      2'd2: begin
        w_rdval[31:16] = r_frame;
        w_rdval[1:0]   = r_idx;
      end
      2'd3: w_rdval = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_en    <= 1'b1;
      r_blank <= '0;
    end else if (w_wr) begin
      unique case (w_off)
        2'd0: r_data <= memwdata_i[15:0];
        2'd1: begin
          r_en    <= memwdata_i[0];
          r_blank <= memwdata_i[7:4];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_hit   <= w_rd;
      r_rdata <= w_rd ? w_rdval : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_idx   <= '0;
      r_frame <= '0;
    end else if (w_wrap) begin
      r_pcnt <= '0;
      r_idx  <= r_idx + 2'd1;
      if (r_idx == 2'd3)
        r_frame <= r_frame + 16'd1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else if (r_en && !r_blank[r_idx]) begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= hex7(w_nib);
    end else begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end
  end

  assign memrdata_o = r_rdata;
  assign hit_o      = r_hit;
  assign seg7_seg_o = r_seg;
  assign seg7_an_o  = r_an;

endmodule
